// File: rtl/alu_acc_seq.sv
// Command sequencer and W-bit accumulator in front of an external combinational ALU.
// LOAD/ADD/SUB complete directly; MUL is performed as repeated ALU adds.
module alu_acc_seq #(
  parameter int         W     = 4,
  parameter logic [4:0] F_ADD = 5'b00010,
  parameter logic [4:0] F_SUB = 5'b00011,
  parameter logic [4:0] F_NOP = 5'b00000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_f,
  input  logic [W-1:0] alu_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t       state_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] opnd_q;
  logic [W-1:0] mcand_q;
  logic [W-1:0] cnt_q;
  logic         cmd_ready_q;
  logic         res_valid_q;
  logic [4:0]   alu_f_q;

  // Control outputs are computed one edge ahead so they come straight from flops;
  // alu_f drops to NOP on the edge that consumes the last multiplier count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      alu_f_q     <= F_NOP;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            unique case (op_t'(cmd_op))
              OP_LOAD: begin
                acc_q       <= cmd_data;
                state_q     <= S_DONE;
                res_valid_q <= 1'b1;
              end
              OP_ADD: begin
                opnd_q  <= cmd_data;
                alu_f_q <= F_ADD;
                state_q <= S_EXEC;
              end
              OP_SUB: begin
                opnd_q  <= cmd_data;
                alu_f_q <= F_SUB;
                state_q <= S_EXEC;
              end
              OP_MUL: begin
                mcand_q <= acc_q;
                cnt_q   <= cmd_data;
                acc_q   <= '0;
                alu_f_q <= (cmd_data != '0) ? F_ADD : F_NOP;
                state_q <= S_MUL;
              end
            endcase
          end
        end
        S_EXEC: begin
          acc_q       <= alu_y;
          alu_f_q     <= F_NOP;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_MUL: begin
          if (cnt_q != '0) begin
            acc_q <= alu_y;
            cnt_q <= cnt_q - W'(1);
            if (cnt_q == W'(1)) begin
              alu_f_q <= F_NOP;
            end
          end else begin
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_b = '0;
    if (state_q == S_EXEC) begin
      alu_b = opnd_q;
    end else if ((state_q == S_MUL) && (cnt_q != '0)) begin
      alu_b = mcand_q;
    end
  end

  assign alu_a     = acc_q;
  assign alu_f     = alu_f_q;
  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_zero  = (acc_q == '0);

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: models the 4-bit ALU and checks results, latency and handshakes
// against directed spec cases and a mod-16 arithmetic reference for random commands.
module tb_alu_acc_seq;
  localparam int         W     = 4;
  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SUB = 5'b00011;
  localparam logic [4:0] F_NOP = 5'b00000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [4:0]   alu_f;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_zero;

  int checks = 0;
  int errors = 0;
  int model_acc = 0;

  alu_acc_seq #(.W(W), .F_ADD(F_ADD), .F_SUB(F_SUB), .F_NOP(F_NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // External ALU: add, subtract, anything else yields 0.
  always_comb begin
    alu_y = '0;
    if (alu_f == F_ADD) alu_y = alu_a + alu_b;
    else if (alu_f == F_SUB) alu_y = alu_a - alu_b;
  end

  // Drives one command, measures latency from accept edge, counts ALU activity,
  // holds the result for 'hold' cycles, then consumes it. Observations only.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d, input int hold,
                         output int lat, output int nadd, output int nsub,
                         output logic [W-1:0] data, output logic zero,
                         output int unstable, output int tmo);
    int b;
    lat = 0; nadd = 0; nsub = 0; unstable = 0; tmo = 0; b = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) tmo = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!res_valid && lat < 100) begin
      if (alu_f == F_ADD) nadd++;
      if (alu_f == F_SUB) nsub++;
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) tmo = 1;
    data = res_data;
    zero = res_zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_data !== data || cmd_ready !== 1'b0) unstable++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) unstable++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready, res_valid, res_data, res_zero, alu_a, alu_b, alu_f} !==
        {1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0, F_NOP}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d z=%b a=%0d b=%0d f=%b expected rdy=1 vld=0 data=0 z=1 a=0 b=0 f=00000",
               cmd_ready, res_valid, res_data, res_zero, alu_a, alu_b, alu_f);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got rdy=%b vld=%b expected rdy=1 vld=0", cmd_ready, res_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0] ops  [10] = '{0, 1, 0, 2, 0, 3, 0, 3, 0, 3};
    int         dat  [10] = '{5, 3, 2, 3, 3, 5, 7, 3, 9, 0};
    int         eres [10] = '{5, 8, 2, 15, 3, 15, 7, 5, 9, 0};
    int         elat [10] = '{0, 1, 0, 1, 0, 6, 0, 4, 0, 1};
    int         eadd [10] = '{0, 1, 0, 0, 0, 5, 0, 3, 0, 0};
    int         esub [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int lat, nadd, nsub, unst, tmo;
    logic [W-1:0] data;
    logic zero;
    for (int i = 0; i < 10; i++) begin
      run_cmd(ops[i], W'(dat[i]), 2, lat, nadd, nsub, data, zero, unst, tmo);
      checks++;
      if (tmo != 0 || data !== W'(eres[i]) || zero !== (eres[i] == 0)) begin
        errors++;
        $display("FAIL directed_result[%0d]: got data=%0d zero=%b timeout=%0d expected data=%0d zero=%b timeout=0",
                 i, data, zero, tmo, eres[i], eres[i] == 0);
      end
      checks++;
      if (lat != elat[i] || nadd != eadd[i] || nsub != esub[i] || unst != 0) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got lat=%0d adds=%0d subs=%0d unstable=%0d expected lat=%0d adds=%0d subs=%0d unstable=0",
                 i, lat, nadd, nsub, unst, elat[i], eadd[i], esub[i]);
      end
    end
    model_acc = 0;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    @(negedge clk);
    cmd_op = 2'b00; cmd_data = 4'd6; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'b01; cmd_data = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_data !== 4'd6 || cmd_ready !== 1'b0 || alu_f !== F_NOP) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d bad cycles (last data=%0d rdy=%b) expected 0", bad, res_data, cmd_ready);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b expected vld=0 rdy=1", res_valid, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || alu_f !== F_ADD) begin
      errors++;
      $display("FAIL held_cmd_accept: got rdy=%b f=%b expected rdy=0 f=00010", cmd_ready, alu_f);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'd7) begin
      errors++;
      $display("FAIL held_cmd_result: got vld=%b data=%0d expected vld=1 data=7", res_valid, res_data);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    model_acc = 7;
  endtask

  task automatic test_reset_mid();
    int lat, nadd, nsub, unst, tmo;
    logic [W-1:0] data;
    logic zero;
    run_cmd(2'b00, 4'd4, 0, lat, nadd, nsub, data, zero, unst, tmo);
    @(negedge clk);
    cmd_op = 2'b11; cmd_data = 4'd6; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (alu_f !== F_ADD || res_valid !== 1'b0 || alu_b !== 4'd4) begin
      errors++;
      $display("FAIL mul_in_progress: got f=%b vld=%b b=%0d expected f=00010 vld=0 b=4", alu_f, res_valid, alu_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_f !== F_NOP || res_data !== 4'd0 || res_zero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_mid: got vld=%b rdy=%b f=%b data=%0d z=%b expected vld=0 rdy=1 f=00000 data=0 z=1",
               res_valid, cmd_ready, alu_f, res_data, res_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL discarded_result: got vld=%b expected 0", res_valid);
    end
    run_cmd(2'b00, 4'd1, 1, lat, nadd, nsub, data, zero, unst, tmo);
    checks++;
    if (tmo != 0 || data !== 4'd1 || zero !== 1'b0 || lat != 0) begin
      errors++;
      $display("FAIL load_after_reset: got data=%0d zero=%b lat=%0d timeout=%0d expected data=1 zero=0 lat=0 timeout=0",
               data, zero, lat, tmo);
    end
    model_acc = 1;
  endtask

  task automatic test_random();
    int lat, nadd, nsub, unst, tmo;
    int op, d, hold, exp_lat, exp_add, exp_sub;
    logic [W-1:0] data;
    logic zero;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 3));
      case (op)
        0: begin model_acc = d; exp_lat = 0; exp_add = 0; exp_sub = 0; end
        1: begin model_acc = (model_acc + d) % 16; exp_lat = 1; exp_add = 1; exp_sub = 0; end
        2: begin model_acc = (model_acc - d + 16) % 16; exp_lat = 1; exp_add = 0; exp_sub = 1; end
        default: begin model_acc = (model_acc * d) % 16; exp_lat = d + 1; exp_add = d; exp_sub = 0; end
      endcase
      run_cmd(2'(op), W'(d), hold, lat, nadd, nsub, data, zero, unst, tmo);
      checks++;
      if (tmo != 0 || data !== W'(model_acc) || zero !== (model_acc == 0)) begin
        errors++;
        $display("FAIL random_result[%0d] op=%0d d=%0d: got data=%0d zero=%b timeout=%0d expected data=%0d zero=%b",
                 i, op, d, data, zero, tmo, model_acc, model_acc == 0);
      end
      checks++;
      if (lat != exp_lat || nadd != exp_add || nsub != exp_sub || unst != 0) begin
        errors++;
        $display("FAIL random_timing[%0d] op=%0d d=%0d: got lat=%0d adds=%0d subs=%0d unstable=%0d expected lat=%0d adds=%0d subs=%0d unstable=0",
                 i, op, d, lat, nadd, nsub, unst, exp_lat, exp_add, exp_sub);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
